// File: rtl/fetch_sequencer_if.sv
// Instruction-fetch bus bundle: imem port, decode handshake, redirect and PC.
// Trap signals exist only when FETCH_MISALIGN_TRAP_EN is defined.
`timescale 1ns/1ps

interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
  logic [31:0] trap_addr;
`endif

`ifdef FETCH_MISALIGN_TRAP_EN
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, pc,
           misalign_trap, trap_addr,
    input  imem_ready, imem_rvalid, imem_rdata, inst_ready,
           redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc,
           misalign_trap, trap_addr,
    output imem_ready, imem_rvalid, imem_rdata, inst_ready,
           redirect, redirect_target
  );
`else
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, pc,
    input  imem_ready, imem_rvalid, imem_rdata, inst_ready,
           redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc,
    output imem_ready, imem_rvalid, imem_rdata, inst_ready,
           redirect, redirect_target
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// RV32I fetch controller: owns the PC, issues one imem fetch at a time and
// hands words to decode; optional FETCH_MISALIGN_TRAP_EN traps misaligned redirects.
`timescale 1ns/1ps

module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef FETCH_MISALIGN_TRAP_EN
  , parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
`endif
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] redirect_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
  logic        trap_q, trap_d;
  logic [31:0] trap_addr_q, trap_addr_d;

  assign misalign    = |bus.redirect_target[1:0];
  assign redirect_pc = misalign ? TRAP_VECTOR : bus.redirect_target;
`else
  // Without the trap, misaligned targets are silently word-aligned.
  assign redirect_pc = bus.redirect_target & 32'hFFFF_FFFC;
`endif

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d       = 1'b0;
    trap_addr_d  = trap_addr_q;
`endif

    if (bus.redirect) begin
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misalign) begin
        trap_d      = 1'b1;
        trap_addr_d = bus.redirect_target;
      end
`endif
      // A request already accepted (or still in flight) becomes stale.
      unique case (state_q)
        S_REQ:           state_d = bus.imem_ready  ? S_DRAIN : S_REQ;
        S_WAIT, S_DRAIN: state_d = bus.imem_rvalid ? S_REQ   : S_DRAIN;
        default:         state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (bus.imem_ready) begin
            fetch_addr_d = pc_q;
            pc_d         = pc_q + 32'd4;
            state_d      = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            inst_d       = bus.imem_rdata;
            inst_pc_d    = fetch_addr_q;
            inst_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_valid_q && bus.inst_ready) begin
            inst_valid_d = 1'b0;
            state_d      = S_REQ;
          end
        end
        S_DRAIN: begin
          if (bus.imem_rvalid) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end

    imem_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VECTOR;
      fetch_addr_q <= RESET_VECTOR;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q       <= 1'b0;
      trap_addr_q  <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      imem_req_q   <= imem_req_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q       <= trap_d;
      trap_addr_q  <= trap_addr_d;
`endif
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.pc         = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.misalign_trap = trap_q;
  assign bus.trap_addr     = trap_addr_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: random memory timing and redirects,
// expected instruction stream derived from the sequential-PC rule.
`timescale 1ns/1ps

module tb_fetch_sequencer;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_VECTOR(RESET_VECTOR)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .TRAP_VECTOR(TRAP_VECTOR)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  // memory model: 0 = random timing, 1 = zero-wait, 2 = ready + 3-cycle latency
  int          mem_mode = 1;
  logic        mem_busy = 1'b0;
  bit          cadence_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, wanted %h", name, act, expv);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return (t[1:0] != 2'b00) ? TRAP_VECTOR : t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  // Instruction memory: one outstanding request, answers even if the fetch went stale.
  initial begin : memory
    logic        acc_flag;
    logic [31:0] acc_addr;
    logic [31:0] resp_addr;
    int          wait_cnt;
    acc_flag = 1'b0;
    acc_addr = '0;
    resp_addr = '0;
    wait_cnt = 0;
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (acc_flag) begin
        resp_addr = acc_addr;
        wait_cnt  = (mem_mode == 1) ? 1 : (mem_mode == 2) ? 3 : int'($urandom_range(1, 3));
        acc_flag  = 1'b0;
      end
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(resp_addr);
        end
      end
      mem_busy = (wait_cnt > 0);
      if (wait_cnt > 0)      bus.imem_ready = 1'b0;
      else if (mem_mode != 0) bus.imem_ready = 1'b1;
      else                   bus.imem_ready = ($urandom_range(0, 3) != 0);
      acc_flag = bus.imem_req && bus.imem_ready;
      acc_addr = bus.imem_addr;
    end
  end

  // Monitor: mid-cycle snapshot; handshakes pop the scoreboard.
  initial begin : monitor
    int          cyc;
    int          last_hs;
    logic        p_hold, p_redir, p_acc;
    logic [31:0] p_pc, p_inst, p_tgt;
    exp_t        e;
    cyc = 0;
    last_hs = -1;
    p_hold = 1'b0;
    p_redir = 1'b0;
    p_acc = 1'b0;
    p_pc = '0;
    p_inst = '0;
    p_tgt = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        p_hold  = 1'b0;
        p_redir = 1'b0;
        p_acc   = 1'b0;
        last_hs = -1;
      end else begin
        if (p_hold) begin
          check("hold_valid", 32'(bus.inst_valid), 32'd1);
          check("hold_inst_pc", bus.inst_pc, p_pc);
          check("hold_inst", bus.inst, p_inst);
        end
        if (bus.inst_valid) check("req_while_holding", 32'(bus.imem_req), 32'd0);
        if (p_redir) begin
          check("redirect_pc", bus.pc, eff_target(p_tgt));
          check("redirect_kills_valid", 32'(bus.inst_valid), 32'd0);
          if (p_acc) check("drain_no_req", 32'(bus.imem_req), 32'd0);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        begin
          logic exp_trap;
          exp_trap = p_redir && (p_tgt[1:0] != 2'b00);
          if (exp_trap || bus.misalign_trap) check("misalign_trap", 32'(bus.misalign_trap), 32'(exp_trap));
          if (exp_trap) check("trap_addr", bus.trap_addr, p_tgt);
        end
`endif
        if (bus.inst_valid && bus.inst_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_inst", 32'(~bus.inst_valid), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("inst_pc", bus.inst_pc, e.pc);
            check("inst", bus.inst, e.word);
          end
          if (cadence_on && last_hs >= 0) check("cadence", 32'(cyc - last_hs), 32'd3);
          last_hs = cyc;
        end
        if (!cadence_on) last_hs = -1;
        p_hold  = bus.inst_valid && !bus.inst_ready && !bus.redirect;
        p_pc    = bus.inst_pc;
        p_inst  = bus.inst;
        p_redir = bus.redirect;
        p_tgt   = bus.redirect_target;
        p_acc   = bus.redirect && bus.imem_req && bus.imem_ready;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    bus.redirect        = 1'b1;
    bus.redirect_target = t;
    tick();
    bus.redirect        = 1'b0;
    bus.redirect_target = $urandom;
  endtask

  // Expect n sequential instructions from start, then let decode stall again.
  task automatic run_seq(input logic [31:0] start, input int n, input int rdy_pct);
    exp_t        e;
    logic [31:0] a;
    int          budget;
    a = start;
    for (int i = 0; i < n; i++) begin
      e.pc   = a;
      e.word = mem_word(a);
      exp_q.push_back(e);
      a = a + 32'd4;
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 400) begin
      bus.inst_ready = (int'($urandom_range(1, 100)) <= rdy_pct);
      tick();
      budget++;
    end
    bus.inst_ready = 1'b0;
    if (exp_q.size() != 0) begin
      check("seq_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic apply_reset();
    bus.inst_ready = 1'b0;
    bus.redirect   = 1'b0;
    reset          = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);
    check("rst_pc", bus.pc, RESET_VECTOR);
    check("rst_imem_addr", bus.imem_addr, RESET_VECTOR);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_misalign_trap", 32'(bus.misalign_trap), 32'd0);
    check("rst_trap_addr", bus.trap_addr, 32'd0);
`endif
    reset = 1'b0;
    check("idle_no_req", 32'(bus.imem_req), 32'd0);
    tick();
    check("first_req", 32'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr, RESET_VECTOR);
  endtask

  task automatic wait_in_wait();
    int b;
    b = 0;
    while (!(mem_busy && !bus.imem_rvalid && !bus.imem_req && !bus.inst_valid) && b < 50) begin
      tick();
      b++;
    end
    if (b >= 50) check("wait_state_timeout", 32'(b), 32'd0);
  endtask

  task automatic wait_in_req();
    int b;
    b = 0;
    while (!(bus.imem_req && !mem_busy) && b < 50) begin
      tick();
      b++;
    end
    if (b >= 50) check("req_state_timeout", 32'(b), 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin : stimulus
    logic [31:0] t;
    int          b;
    reset               = 1'b1;
    bus.inst_ready      = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;

    // zero-wait sequential fetch from reset, one instruction per 3 cycles
    mem_mode = 1;
    apply_reset();
    cadence_on = 1'b1;
    run_seq(RESET_VECTOR, 4, 100);
    cadence_on = 1'b0;

    // decode stalls on a held instruction
    b = 0;
    while (!bus.inst_valid && b < 50) begin
      tick();
      b++;
    end
    if (b >= 50) check("hold_timeout", 32'(b), 32'd0);
    repeat (5) tick();
    run_seq(32'h0000_0010, 2, 100);

    // redirect while waiting for a slow response
    mem_mode = 2;
    wait_in_wait();
    do_redirect(32'h0000_0200);
    run_seq(32'h0000_0200, 3, 100);

    // redirect in the same cycle the request is accepted
    mem_mode = 1;
    wait_in_req();
    do_redirect(32'h0000_0480);
    run_seq(32'h0000_0480, 2, 100);

    // PC wraps past the top of the address space
    mem_mode = 0;
    repeat (3) tick();
    do_redirect(32'hFFFF_FFFC);
    run_seq(32'hFFFF_FFFC, 3, 70);

    // misaligned target
    repeat (2) tick();
    do_redirect(32'h0000_0102);
    run_seq(eff_target(32'h0000_0102), 2, 100);

    // second redirect lands while draining
    mem_mode = 2;
    wait_in_wait();
    do_redirect(32'h0000_0300);
    tick();
    do_redirect(32'h0000_0340);
    run_seq(32'h0000_0340, 2, 100);

    // random redirects at arbitrary points of the fetch cycle
    for (int i = 0; i < 30; i++) begin
      mem_mode = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 8)) tick();
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      do_redirect(t);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 2)) tick();
        t = $urandom;
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
        do_redirect(t);
      end
      run_seq(eff_target(t), int'($urandom_range(1, 4)), int'($urandom_range(50, 100)));
    end

    // reset in the middle of a fetch, possibly with a response still owed
    mem_mode = 0;
    run_seq(bus.pc, 0, 100);
    repeat ($urandom_range(0, 2)) tick();
    apply_reset();
    run_seq(RESET_VECTOR, 3, 80);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
